// File: rtl/trng_uart_framer.sv
// trng_uart_framer: buffers random words from a TRNG in a small FIFO and frames
// them for a byte-wide UART transmitter.
//   Binary frame : A5, FRAME_WORDS words MSB first, XOR checksum.
//   Hex frame    : payload and checksum as uppercase ASCII hex, then CR LF.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_word_in       random word, qualified by i_word_valid
//   o_word_ready    FIFO not full (words offered while full are dropped)
//   i_hex_mode      framing select, latched when a frame starts
//   o_tx_data       byte for the UART, held until the next launch
//   o_tx_start      one-cycle launch pulse
//   i_tx_busy       UART busy, launches wait for it to be low
//   o_frame_done    pulses with the final launch of a frame
//   o_overflow_cnt  saturating count of dropped words
module trng_uart_framer #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned FRAME_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] i_word_in,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  input  logic              i_hex_mode,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  output logic              o_frame_done,
  output logic [15:0]       o_overflow_cnt
);

  localparam int unsigned BYTES = WORD_W / 8;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned WI_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FRAME_C   = CNT_W'(FRAME_WORDS);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [BI_W-1:0]  BYTE_LAST = BI_W'(BYTES - 1);
  localparam logic [WI_W-1:0]  WORD_LAST = WI_W'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {IDLE, HDR, PAY, CSUM, EOL, GAP} state_e;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // ---------------------------------------------------------------- FIFO
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [15:0]       r_overflow_cnt;
  logic              w_full, w_push, w_drop, w_pop;
  logic [WORD_W-1:0] w_head;

  // Full comes from the registered count only, so a same-cycle pop never
  // rescues a word offered while full.
  assign w_full = (r_count == DEPTH_C);
  assign w_push = i_word_valid & ~w_full;
  assign w_drop = i_word_valid & w_full;
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_word_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_overflow_cnt <= 16'h0000;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_drop && (r_overflow_cnt != 16'hFFFF)) r_overflow_cnt <= r_overflow_cnt + 16'd1;
    end
  end

  // ------------------------------------------------------------- framer
  state_e          r_state, r_ret, w_state_nxt, w_ret_nxt;
  logic            r_hex, r_nib, r_eol, w_hex_nxt, w_nib_nxt, w_eol_nxt;
  logic [BI_W-1:0] r_byte_idx, w_byte_idx_nxt;
  logic [WI_W-1:0] r_word_idx, w_word_idx_nxt;
  logic [7:0]      r_csum, w_csum_nxt;
  logic [7:0]      r_tx_data, w_launch_data, w_byte;
  logic            r_tx_start, r_frame_done, w_launch, w_last;

  // Byte index counts down so the most-significant byte goes first.
  assign w_byte = w_head[{r_byte_idx, 3'b000} +: 8];

  always_comb begin
    w_state_nxt    = r_state;
    w_ret_nxt      = r_ret;
    w_hex_nxt      = r_hex;
    w_nib_nxt      = r_nib;
    w_eol_nxt      = r_eol;
    w_byte_idx_nxt = r_byte_idx;
    w_word_idx_nxt = r_word_idx;
    w_csum_nxt     = r_csum;
    w_launch       = 1'b0;
    w_launch_data  = 8'h00;
    w_last         = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count >= FRAME_C) begin
          w_state_nxt    = HDR;
          w_hex_nxt      = i_hex_mode;
          w_csum_nxt     = 8'h00;
          w_byte_idx_nxt = BYTE_LAST;
          w_word_idx_nxt = '0;
          w_nib_nxt      = 1'b0;
          w_eol_nxt      = 1'b0;
        end
      end
      HDR: begin
        if (r_hex) begin
          w_state_nxt = PAY;
        end else if (!i_tx_busy) begin
          w_launch      = 1'b1;
          w_launch_data = 8'hA5;
          w_ret_nxt     = PAY;
        end
      end
      PAY: begin
        if (!i_tx_busy) begin
          w_launch  = 1'b1;
          w_ret_nxt = PAY;
          if (r_hex && !r_nib) begin
            w_launch_data = hex_char(w_byte[7:4]);
            w_nib_nxt     = 1'b1;
          end else begin
            w_launch_data = r_hex ? hex_char(w_byte[3:0]) : w_byte;
            w_nib_nxt     = 1'b0;
            w_csum_nxt    = r_csum ^ w_byte;
            if (r_byte_idx == '0) begin
              w_pop          = 1'b1;
              w_byte_idx_nxt = BYTE_LAST;
              if (r_word_idx == WORD_LAST) w_ret_nxt = CSUM;
              else                         w_word_idx_nxt = r_word_idx + 1'b1;
            end else begin
              w_byte_idx_nxt = r_byte_idx - 1'b1;
            end
          end
        end
      end
      CSUM: begin
        if (!i_tx_busy) begin
          w_launch = 1'b1;
          if (r_hex && !r_nib) begin
            w_launch_data = hex_char(r_csum[7:4]);
            w_nib_nxt     = 1'b1;
            w_ret_nxt     = CSUM;
          end else if (r_hex) begin
            w_launch_data = hex_char(r_csum[3:0]);
            w_nib_nxt     = 1'b0;
            w_ret_nxt     = EOL;
          end else begin
            w_launch_data = r_csum;
            w_last        = 1'b1;
            w_ret_nxt     = IDLE;
          end
        end
      end
      EOL: begin
        if (!i_tx_busy) begin
          w_launch = 1'b1;
          if (!r_eol) begin
            w_launch_data = 8'h0D;
            w_eol_nxt     = 1'b1;
            w_ret_nxt     = EOL;
          end else begin
            w_launch_data = 8'h0A;
            w_last        = 1'b1;
            w_ret_nxt     = IDLE;
          end
        end
      end
      // One dead cycle lets the UART raise busy before the next launch.
      GAP:     w_state_nxt = r_ret;
      default: w_state_nxt = IDLE;
    endcase
    if (w_launch) w_state_nxt = GAP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ret        <= IDLE;
      r_hex        <= 1'b0;
      r_nib        <= 1'b0;
      r_eol        <= 1'b0;
      r_byte_idx   <= '0;
      r_word_idx   <= '0;
      r_csum       <= 8'h00;
      r_tx_data    <= 8'h00;
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ret        <= w_ret_nxt;
      r_hex        <= w_hex_nxt;
      r_nib        <= w_nib_nxt;
      r_eol        <= w_eol_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_word_idx   <= w_word_idx_nxt;
      r_csum       <= w_csum_nxt;
      if (w_launch) r_tx_data <= w_launch_data;
      r_tx_start   <= w_launch;
      r_frame_done <= w_launch & w_last;
    end
  end

  assign o_word_ready   = ~w_full;
  assign o_tx_data      = r_tx_data;
  assign o_tx_start     = r_tx_start;
  assign o_frame_done   = r_frame_done;
  assign o_overflow_cnt = r_overflow_cnt;

endmodule

// File: tb/tb_trng_uart_framer.sv
// Bench for trng_uart_framer (WORD_W=32, FIFO_DEPTH=4, FRAME_WORDS=2) with a
// UART model that stays busy for 10 cycles after every launch.
module tb_trng_uart_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        hex_mode;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        frame_done;
  logic [15:0] overflow_cnt;

  trng_uart_framer #(
    .WORD_W      (32),
    .FIFO_DEPTH  (4),
    .FRAME_WORDS (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_word_in      (word_in),
    .i_word_valid   (word_valid),
    .o_word_ready   (word_ready),
    .i_hex_mode     (hex_mode),
    .o_tx_data      (tx_data),
    .o_tx_start     (tx_start),
    .i_tx_busy      (tx_busy),
    .o_frame_done   (frame_done),
    .o_overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // UART model
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start === 1'b1) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  // Byte capture and launch protocol monitor
  logic [7:0] got_q[$];
  int         fd_idx_q[$];
  int         fd_cnt = 0;
  logic       prev_start = 1'b0;
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      checks++;
      if (prev_start || tx_busy)
        $display("FAIL tx_start_protocol: prev_start=%0b tx_busy=%0b, required 0 and 0",
                 prev_start, tx_busy);
      else passed++;
      got_q.push_back(tx_data);
    end
    if (frame_done === 1'b1) begin
      checks++;
      if (tx_start !== 1'b1)
        $display("FAIL frame_done_with_start: tx_start=%b, required 1", tx_start);
      else passed++;
      fd_idx_q.push_back(got_q.size() - 1);
      fd_cnt++;
    end
    prev_start = tx_start;
  end

  // Reference model: expected byte stream and frame_done positions
  logic [7:0] exp_q[$];
  int         exp_fd_q[$];

  task automatic add_frame(input logic [31:0] wa, input logic [31:0] wb, input bit hex);
    logic [31:0] ws[2];
    logic [7:0]  pay[$];
    logic [7:0]  cs;
    string       hx;
    hx = "0123456789ABCDEF";
    ws[0] = wa;
    ws[1] = wb;
    cs = 8'h00;
    for (int w = 0; w < 2; w++)
      for (int b = 3; b >= 0; b--) pay.push_back(8'((ws[w] >> (8 * b)) & 32'hFF));
    foreach (pay[i]) cs ^= pay[i];
    pay.push_back(cs);
    if (!hex) begin
      exp_q.push_back(8'hA5);
      foreach (pay[i]) exp_q.push_back(pay[i]);
    end else begin
      foreach (pay[i]) begin
        exp_q.push_back(hx[int'(pay[i] / 16)]);
        exp_q.push_back(hx[int'(pay[i] % 16)]);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    exp_fd_q.push_back(exp_q.size() - 1);
  endtask

  // Stimulus helpers
  task automatic start_capture();
    got_q.delete();
    fd_idx_q.delete();
    exp_q.delete();
    exp_fd_q.delete();
    fd_cnt = 0;
  endtask

  task automatic push(input logic [31:0] w);
    @(negedge clk);
    word_in    = w;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    repeat (20) @(posedge clk);
  endtask

  task automatic wait_frames(input int n, output bit ok);
    int cyc = 0;
    while (fd_cnt < n && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    ok = (fd_cnt >= n);
    @(posedge clk);
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    int cyc = 0;
    while (got_q.size() < n && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    ok = (got_q.size() >= n);
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (word_ready !== 1'b1) $display("FAIL rst_word_ready: got %b, required 1", word_ready); else passed++;
    checks++; if (tx_start !== 1'b0) $display("FAIL rst_tx_start: got %b, required 0", tx_start); else passed++;
    checks++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h, required 00", tx_data); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b, required 0", frame_done); else passed++;
    checks++; if (overflow_cnt !== 16'h0000) $display("FAIL rst_overflow: got %h, required 0000", overflow_cnt); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_start !== 1'b0 || word_ready !== 1'b1)
      $display("FAIL post_rst_idle: start=%b ready=%b, required 0 1", tx_start, word_ready);
    else passed++;
  endtask

  task automatic test_binary();
    bit ok;
    start_capture();
    hex_mode = 1'b0;
    add_frame(32'h01020304, 32'hA0B0C0D0, 1'b0);
    push(32'h01020304);
    push(32'hA0B0C0D0);
    @(posedge clk); #1;
    checks++; if (tx_start !== 1'b0) $display("FAIL latency_early: tx_start=%b, required 0", tx_start); else passed++;
    @(posedge clk); #1;
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5)
      $display("FAIL latency_first: start=%b data=%h, required 1 a5", tx_start, tx_data);
    else passed++;
    wait_frames(1, ok);
    checks++; if (!ok) $display("FAIL bin_timeout: frames=%0d, required 1", fd_cnt); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL bin_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    checks++; if (fd_idx_q.size() != 1 || fd_idx_q[0] != exp_fd_q[0])
      $display("FAIL bin_frame_done: count=%0d, required 1 at byte %0d", fd_idx_q.size(), exp_fd_q[0]);
    else passed++;
  endtask

  task automatic test_hex();
    bit ok;
    wait_quiet();
    start_capture();
    hex_mode = 1'b1;
    add_frame(32'h00FF1234, 32'hDEADBEEF, 1'b1);
    push(32'h00FF1234);
    push(32'hDEADBEEF);
    wait_bytes(1, ok);
    hex_mode = 1'b0;  // must not disturb the frame in progress
    wait_frames(1, ok);
    checks++; if (!ok) $display("FAIL hex_timeout: frames=%0d, required 1", fd_cnt); else passed++;
    checks++; if (got_q.size() != 20) $display("FAIL hex_len: got %0d, required 20", got_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL hex_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    checks++; if (fd_idx_q.size() != 1 || fd_idx_q[0] != 19)
      $display("FAIL hex_frame_done: count=%0d, required 1 at byte 19", fd_idx_q.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] ws[4];
    wait_quiet();
    start_capture();
    hex_mode = 1'b0;
    foreach (ws[i]) ws[i] = $urandom;
    add_frame(ws[0], ws[1], 1'b0);
    add_frame(ws[2], ws[3], 1'b0);
    foreach (ws[i]) begin
      push(ws[i]);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_frames(2, ok);
    checks++; if (!ok) $display("FAIL b2b_timeout: frames=%0d, required 2", fd_cnt); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL b2b_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (fd_idx_q[i] !== exp_fd_q[i])
        $display("FAIL b2b_frame_done[%0d]: got byte %0d, required %0d", i, fd_idx_q[i], exp_fd_q[i]);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [31:0] ws[7];
    wait_quiet();
    start_capture();
    hex_mode = 1'b0;
    foreach (ws[i]) ws[i] = $urandom;
    @(negedge clk);
    force_busy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      word_in    = ws[i];
      word_valid = 1'b1;
      #1;
      checks++;
      if (word_ready !== (i < 4)) $display("FAIL ovf_ready[%0d]: got %b, required %b", i, word_ready, i < 4);
      else passed++;
    end
    @(negedge clk);
    word_valid = 1'b0;
    #1;
    checks++; if (overflow_cnt !== 16'd3) $display("FAIL ovf_count: got %0d, required 3", overflow_cnt); else passed++;
    force_busy = 1'b0;
    add_frame(ws[0], ws[1], 1'b0);
    add_frame(ws[2], ws[3], 1'b0);
    wait_frames(2, ok);
    checks++; if (!ok) $display("FAIL ovf_timeout: frames=%0d, required 2", fd_cnt); else passed++;
    checks++; if (got_q.size() != exp_q.size())
      $display("FAIL ovf_len: got %0d, required %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL ovf_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_saturate();
    wait_quiet();
    @(negedge clk);
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      word_in    = $urandom;
      word_valid = 1'b1;
    end
    @(negedge clk);
    word_valid = 1'b0;
    force dut.r_overflow_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_overflow_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      word_in    = $urandom;
      word_valid = 1'b1;
    end
    @(negedge clk);
    word_valid = 1'b0;
    #1;
    checks++; if (overflow_cnt !== 16'hFFFF) $display("FAIL ovf_saturate: got %h, required ffff", overflow_cnt); else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force_busy = 1'b0;
    #1;
    checks++; if (overflow_cnt !== 16'h0000 || word_ready !== 1'b1)
      $display("FAIL sat_reset: ovf=%h ready=%b, required 0000 1", overflow_cnt, word_ready);
    else passed++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int starts;
    logic [31:0] wa, wb;
    wait_quiet();
    start_capture();
    hex_mode = 1'b0;
    push($urandom);
    push($urandom);
    wait_bytes(5, ok);
    checks++; if (!ok) $display("FAIL midrst_timeout: bytes=%0d, required 5", got_q.size()); else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    starts = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) starts++;
    end
    checks++; if (starts != 0) $display("FAIL midrst_quiet: got %0d starts, required 0", starts); else passed++;
    checks++; if (word_ready !== 1'b1) $display("FAIL midrst_ready: got %b, required 1", word_ready); else passed++;
    start_capture();
    wa = $urandom;
    wb = $urandom;
    add_frame(wa, wb, 1'b0);
    push(wa);
    push(wb);
    wait_frames(1, ok);
    checks++; if (!ok) $display("FAIL midrst_frame_timeout: frames=%0d, required 1", fd_cnt); else passed++;
    checks++; if (got_q[0] !== 8'hA5) $display("FAIL midrst_header: got %h, required a5", got_q[0]); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL midrst_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    bit ok;
    bit hex;
    logic [31:0] wa, wb;
    for (int f = 0; f < 6; f++) begin
      wait_quiet();
      start_capture();
      hex      = 1'($urandom_range(0, 1));
      hex_mode = hex;
      wa       = $urandom;
      wb       = $urandom;
      add_frame(wa, wb, hex);
      push(wa);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      push(wb);
      wait_bytes(1, ok);
      hex_mode = 1'($urandom_range(0, 1));
      wait_frames(1, ok);
      checks++; if (!ok) $display("FAIL rnd%0d_timeout: frames=%0d, required 1", f, fd_cnt); else passed++;
      checks++; if (got_q.size() != exp_q.size())
        $display("FAIL rnd%0d_len: got %0d, required %0d", f, got_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i])
          $display("FAIL rnd%0d_byte[%0d]: got %h, required %h", f, i, got_q[i], exp_q[i]);
        else passed++;
      end
      checks++; if (fd_idx_q.size() != 1 || fd_idx_q[0] != exp_fd_q[0])
        $display("FAIL rnd%0d_frame_done: count=%0d, required 1 at byte %0d", f, fd_idx_q.size(), exp_fd_q[0]);
      else passed++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    word_in    = 32'h0;
    word_valid = 1'b0;
    hex_mode   = 1'b0;
    test_reset();
    test_binary();
    test_hex();
    test_back_to_back();
    test_overflow();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/trng_uart_framer.md
TRNG_UART_FRAMER -- requirements
Module: trng_uart_framer

Interface
REQ-001 Parameter WORD_W, default 32: random word width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter FIFO_DEPTH, default 4: word FIFO depth; SHALL be a power of 2, at least FRAME_WORDS.
REQ-003 Parameter FRAME_WORDS, default 4: words per frame, range 1..FIFO_DEPTH.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port word_in, input, WORD_W: random word from the TRNG.
REQ-007 Port word_valid, input, 1: word_in is valid this cycle.
REQ-008 Port word_ready, output, 1: FIFO can accept a word this cycle.
REQ-009 Port hex_mode, input, 1: 0 selects binary framing, 1 selects ASCII-hex framing; sampled at frame start.
REQ-010 Port tx_data, output, 8: byte presented to the UART transmitter.
REQ-011 Port tx_start, output, 1: one-cycle pulse launching tx_data.
REQ-012 Port tx_busy, input, 1: UART transmitter is busy.
REQ-013 Port frame_done, output, 1: one-cycle pulse when the last byte of a frame is launched.
REQ-014 Port overflow_cnt, output, 16: count of dropped words, saturating.

Function
REQ-015 word_ready SHALL equal NOT full, derived from registered FIFO occupancy; a word SHALL be pushed only when word_valid and word_ready are both high.
REQ-016 A word offered while the FIFO is full SHALL be dropped and SHALL increment overflow_cnt, which saturates at 0xFFFF; a same-cycle pop SHALL NOT make room for that word.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be FIFO_DEPTH-aware, so full and empty are unambiguous.
REQ-018 FSM states SHALL be IDLE, HDR, PAY, CSUM, EOL and GAP.
REQ-019 IDLE SHALL move to HDR when occupancy is at least FRAME_WORDS; hex_mode is latched on that transition.
REQ-020 HDR, binary mode: send 0xA5. Hex mode: send no header and go directly to PAY.
REQ-021 PAY SHALL send FRAME_WORDS words, each most-significant byte first.
REQ-022 Each word SHALL be popped in the cycle its last byte (binary) or last character (hex) is launched.
REQ-023 CSUM SHALL send the XOR of all payload bytes of the frame; the checksum register clears at frame start.
REQ-024 In hex mode, every payload and checksum byte SHALL be sent as two uppercase ASCII characters, high nibble first (0-9 as 0x30-0x39, A-F as 0x41-0x46).
REQ-025 EOL (hex mode only) SHALL send 0x0D then 0x0A; binary mode SHALL go from CSUM directly to IDLE.
REQ-026 A byte launch SHALL occur only when tx_busy is low; launching means tx_data is registered and tx_start is pulsed high for exactly one cycle.
REQ-027 After each launch, the FSM SHALL enter GAP for one cycle, ignoring tx_busy, then resume and wait for tx_busy low; back-to-back tx_start pulses SHALL never occur.
REQ-028 tx_data SHALL hold its value until the next launch.
REQ-029 frame_done SHALL pulse in the same cycle as the final tx_start of the frame: the checksum byte in binary mode, 0x0A in hex mode.
REQ-030 FIFO pushes SHALL continue during frame transmission; a frame in progress SHALL NOT be aborted by FIFO-full or by hex_mode changes.
REQ-031 Latency: from the FRAME_WORDS-th word pushed into an otherwise empty FIFO with tx_busy low, the first tx_start SHALL occur 2 cycles later.

Reset
REQ-032 On rst: FIFO empty, word_ready=1, tx_start=0, tx_data=0x00, frame_done=0, overflow_cnt=0, FSM=IDLE, checksum=0.
REQ-033 rst asserted mid-frame SHALL discard the frame and all FIFO contents; no further tx_start SHALL be issued until a new frame qualifies.

Verification (WORD_W=32, FIFO_DEPTH=4, FRAME_WORDS=2; UART model busy for 10 cycles per byte)
REQ-034 Binary mode, push 0x01020304 then 0xA0B0C0D0 -> bytes A5 01 02 03 04 A0 B0 C0 D0 04; frame_done on the last byte.
REQ-035 Hex mode, push 0x00FF1234 then 0xDEADBEEF -> ASCII "00FF1234DEADBEEFFB" then 0D 0A.
REQ-036 Hold tx_busy high and push 7 words -> first 4 accepted, word_ready=0, overflow_cnt=3; after release, frame 1 (words 1-2) is sent, then frame 2 (words 3-4).
REQ-037 Force overflow_cnt to 0xFFFE, then drop 3 words -> overflow_cnt=0xFFFF.
REQ-038 Assert rst after the 5th byte of a frame -> tx_start stays 0 and word_ready=1; after 2 new pushes, a fresh frame starting with A5 is sent.
REQ-039 Throughout all scenarios, check that tx_start is never high in two consecutive cycles and never high while tx_busy is high.
